pru_cmd_arbiter: RTL and testbench

//  Sequences draw commands into the PRU preprocessor. Two requesters (e.g. CPU MMIO path, sprite engine)

---
 rtl/pru_cmd_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_pru_cmd_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pru_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// pru_cmd_arbiter
//
// Purpose:
//   Feeds draw commands to the PRU preprocessor from two requesters. Each
//   command is 64 bits: two 32-bit preprocessor words. Arbitration is
//   round-robin, one whole command at a time. The granted command is
//   buffered and streamed as word0 then word1 over the pp_write/pp_ack
//   handshake. The next command is held off until the PRU pulses pru_done.
//
// Parameters:
//   TIMEOUT_CYCLES  WAIT_DONE watchdog limit in clk cycles. It only has an
//                   effect when PRU_ARB_TIMEOUT_EN is defined.
//   CNT_W           width of the completed-command counter.
//
// Optional feature (macro PRU_ARB_TIMEOUT_EN):
//   When the macro is defined, a watchdog counts cycles in WAIT_DONE. If
//   TIMEOUT_CYCLES pass without pru_done, the command is abandoned: there is
//   no done pulse, cmd_count does not change, and timeout_err is set and
//   stays set until rst. When the macro is not defined, WAIT_DONE waits
//   indefinitely and timeout_err is tied to 0.
//
// Ports:
//   clk, rst                   clock; synchronous active-high reset
//   req0_valid/req0_cmd        requester 0 command request
//   req0_grant/req0_done       1-cycle pulses: command latched / completed
//   req1_valid/req1_cmd        requester 1 command request
//   req1_grant/req1_done       1-cycle pulses: command latched / completed
//   pp_write/pp_data/pp_ack    word stream to the preprocessor
//   pru_done                   PRU completion pulse
//   busy                       high in any state other than IDLE
//   owner                      requester whose command is in flight
//   cmd_count                  completed commands, wraps at 2^CNT_W
//   timeout_err                sticky watchdog error
// -----------------------------------------------------------------------------
module pru_cmd_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [63:0]      req0_cmd,
    output logic             req0_grant,
    output logic             req0_done,
    input  logic             req1_valid,
    input  logic [63:0]      req1_cmd,
    output logic             req1_grant,
    output logic             req1_done,
    output logic             pp_write,
    output logic [31:0]      pp_data,
    input  logic             pp_ack,
    input  logic             pru_done,
    output logic             busy,
    output logic             owner,
    output logic [CNT_W-1:0] cmd_count,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND0     = 2'd1,
        ST_SEND1     = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [63:0]      r_cmd_buf;
    logic             r_owner;
    logic             r_rr_ptr;      // requester preferred on the next tie
    logic [CNT_W-1:0] r_cmd_count;

    logic w_any_valid;
    logic w_winner;
    logic w_latch;
    logic w_complete;
    logic w_wd_expire;

    assign w_any_valid = req0_valid | req1_valid;

    // When both requesters are valid, the round-robin pointer decides.
    // Otherwise the single valid requester wins. With no request pending
    // the value is unused.
    always_comb begin
        if (req0_valid && req1_valid) begin
            w_winner = r_rr_ptr;
        end else begin
            w_winner = req1_valid;
        end
    end

    // Grant and done are combinational. A grant is seen in the same cycle
    // that the command is captured, so word1 can be accepted 2 cycles after
    // the grant. Both pulses are masked during rst, so an abandoned command
    // never reports completion.
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_complete   = 1'b0;
        req0_grant   = 1'b0;
        req1_grant   = 1'b0;
        req0_done    = 1'b0;
        req1_done    = 1'b0;
        pp_write     = 1'b0;
        pp_data      = 32'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_valid && !rst) begin
                    w_latch      = 1'b1;
                    req0_grant   = ~w_winner;
                    req1_grant   = w_winner;
                    w_state_next = ST_SEND0;
                end
            end
            ST_SEND0: begin
                pp_write = 1'b1;
                pp_data  = r_cmd_buf[31:0];
                if (pp_ack) begin
                    w_state_next = ST_SEND1;
                end
            end
            ST_SEND1: begin
                pp_write = 1'b1;
                pp_data  = r_cmd_buf[63:32];
                if (pp_ack) begin
                    w_state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (pru_done) begin
                    w_state_next = ST_IDLE;
                    w_complete   = 1'b1;
                    if (!rst) begin
                        req0_done = ~r_owner;
                        req1_done = r_owner;
                    end
                end else if (w_wd_expire) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cmd_buf   <= 64'd0;
            r_owner     <= 1'b0;
            r_rr_ptr    <= 1'b0;
            r_cmd_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_latch) begin
                r_cmd_buf <= w_winner ? req1_cmd : req0_cmd;
                r_owner   <= w_winner;
                r_rr_ptr  <= ~w_winner;
            end
            if (w_complete) begin
                r_cmd_count <= r_cmd_count + CNT_W'(1);
            end
        end
    end

`ifdef PRU_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_timeout_err;

    // The counter is held at zero outside WAIT_DONE, so it starts from zero
    // every time WAIT_DONE is entered. It expires on the last of
    // TIMEOUT_CYCLES waiting cycles.
    assign w_wd_expire = (r_state == ST_WAIT_DONE) && !pru_done &&
                         (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state != ST_WAIT_DONE) begin
                r_wd_cnt <= '0;
            end else begin
                r_wd_cnt <= r_wd_cnt + WD_W'(1);
            end
            if (w_wd_expire) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic [31:0] w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
    assign w_wd_expire          = 1'b0;
    assign timeout_err          = 1'b0;
`endif

    assign busy      = (r_state != ST_IDLE);
    assign owner     = r_owner;
    assign cmd_count = r_cmd_count;

endmodule

// File: tb/tb_pru_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pru_cmd_arbiter
//
// Table-driven, cycle-by-cycle bench. Each row gives the inputs for one clock
// cycle and the outputs expected in that same cycle. Inputs are driven on the
// falling edge and the outputs are checked 1 ns later. The rows cover:
//   - a single command,
//   - four-way contention after reset,
//   - a slow ack,
//   - spurious pru_done pulses,
//   - reset in the middle of SEND1.
// The watchdog rows are added only when PRU_ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_pru_cmd_arbiter;

    localparam logic [31:0] W0A = 32'h0011_2233;
    localparam logic [31:0] W1A = 32'h0040_0A55;
    localparam logic [31:0] W0B = 32'h1234_5678;
    localparam logic [31:0] W1B = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [63:0] req0_cmd;
    logic        req0_grant;
    logic        req0_done;
    logic        req1_valid;
    logic [63:0] req1_cmd;
    logic        req1_grant;
    logic        req1_done;
    logic        pp_write;
    logic [31:0] pp_data;
    logic        pp_ack;
    logic        pru_done;
    logic        busy;
    logic        owner;
    logic [15:0] cmd_count;
    logic        timeout_err;

    pru_cmd_arbiter #(
        .TIMEOUT_CYCLES (8),
        .CNT_W          (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_cmd    (req0_cmd),
        .req0_grant  (req0_grant),
        .req0_done   (req0_done),
        .req1_valid  (req1_valid),
        .req1_cmd    (req1_cmd),
        .req1_grant  (req1_grant),
        .req1_done   (req1_done),
        .pp_write    (pp_write),
        .pp_data     (pp_data),
        .pp_ack      (pp_ack),
        .pru_done    (pru_done),
        .busy        (busy),
        .owner       (owner),
        .cmd_count   (cmd_count),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row of the table: the inputs for one cycle, then the outputs
    // expected in that cycle, packed as
    // {g0, g1, wr, data[31:0], d0, d1, busy, owner, count[15:0], terr}.
    typedef struct {
        logic        rst;
        logic        v0;
        logic        v1;
        logic        ack;
        logic        pd;
        logic [55:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   total;
    int   bad;

    task automatic add(input logic r, input logic v0, input logic v1,
                       input logic ack, input logic pd,
                       input logic g0, input logic g1, input logic wr,
                       input logic [31:0] d, input logic d0, input logic d1,
                       input logic bz, input logic own,
                       input logic [15:0] cnt, input logic terr);
        vec_t v;
        v.rst = r;
        v.v0  = v0;
        v.v1  = v1;
        v.ack = ack;
        v.pd  = pd;
        v.exp = {g0, g1, wr, d, d0, d1, bz, own, cnt, terr};
        vecs.push_back(v);
    endtask

    function automatic logic [55:0] outs();
        return {req0_grant, req1_grant, pp_write, pp_data, req0_done,
                req1_done, busy, owner, cmd_count, timeout_err};
    endfunction

    initial begin
        logic [55:0] got;
        logic        w;
        logic        prev;

        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        pp_ack     = 1'b0;
        pru_done   = 1'b0;
        req0_cmd   = {W1A, W0A};
        req1_cmd   = {W1B, W0B};

        // Single command from requester 0, acked in the same cycle.
        add(0,1,0,0,0, 1,0,0,32'd0,0,0,0,0,16'd0,0);
        add(0,0,0,1,0, 0,0,1,W0A,  0,0,1,0,16'd0,0);
        add(0,0,0,1,0, 0,0,1,W1A,  0,0,1,0,16'd0,0);
        for (int i = 0; i < 4; i++)
            add(0,0,0,0,0, 0,0,0,32'd0,0,0,1,0,16'd0,0);
        add(0,0,0,0,1, 0,0,0,32'd0,1,0,1,0,16'd0,0);
        add(0,0,0,0,0, 0,0,0,32'd0,0,0,0,0,16'd1,0);
        add(1,0,0,0,0, 0,0,0,32'd0,0,0,0,0,16'd1,0);

        // Contention after reset: grants alternate req0, req1, req0, req1.
        for (int k = 0; k < 4; k++) begin
            w    = k[0];
            prev = (k == 0) ? 1'b0 : ~w;
            add(0,1,1,0,0, ~w,w,0,32'd0,0,0,0,prev,16'(k),0);
            add(0,1,1,1,0, 0,0,1,(w ? W0B : W0A),0,0,1,w,16'(k),0);
            add(0,1,1,1,0, 0,0,1,(w ? W1B : W1A),0,0,1,w,16'(k),0);
            add(0,1,1,0,1, 0,0,0,32'd0,~w,w,1,w,16'(k),0);
        end
        add(0,0,0,0,0, 0,0,0,32'd0,0,0,0,1,16'd4,0);

        // Only req1 is valid, and ack is held low for 3 cycles in SEND0.
        add(0,0,1,0,0, 0,1,0,32'd0,0,0,0,1,16'd4,0);
        for (int i = 0; i < 3; i++)
            add(0,0,0,0,0, 0,0,1,W0B,0,0,1,1,16'd4,0);
        add(0,0,0,1,0, 0,0,1,W0B,  0,0,1,1,16'd4,0);
        add(0,0,0,0,0, 0,0,1,W1B,  0,0,1,1,16'd4,0);
        add(0,0,0,1,0, 0,0,1,W1B,  0,0,1,1,16'd4,0);
        add(0,0,0,0,0, 0,0,0,32'd0,0,0,1,1,16'd4,0);
        add(0,0,0,0,1, 0,0,0,32'd0,0,1,1,1,16'd4,0);

        // Spurious pru_done in IDLE and in SEND0 is ignored.
        add(0,0,0,0,1, 0,0,0,32'd0,0,0,0,1,16'd5,0);
        add(0,1,0,0,0, 1,0,0,32'd0,0,0,0,1,16'd5,0);
        add(0,0,0,0,1, 0,0,1,W0A,  0,0,1,0,16'd5,0);
        add(0,0,0,1,0, 0,0,1,W0A,  0,0,1,0,16'd5,0);
        add(0,0,0,1,0, 0,0,1,W1A,  0,0,1,0,16'd5,0);
        add(0,0,0,0,0, 0,0,0,32'd0,0,0,1,0,16'd5,0);
        add(0,0,0,0,1, 0,0,0,32'd0,1,0,1,0,16'd5,0);
        add(0,0,0,0,0, 0,0,0,32'd0,0,0,0,0,16'd6,0);

        // Reset during SEND1: no done pulse, and the next command restarts
        // at word0.
        add(0,1,0,0,0, 1,0,0,32'd0,0,0,0,0,16'd6,0);
        add(0,0,0,1,0, 0,0,1,W0A,  0,0,1,0,16'd6,0);
        add(1,0,0,0,1, 0,0,1,W1A,  0,0,1,0,16'd6,0);
        add(0,0,0,0,0, 0,0,0,32'd0,0,0,0,0,16'd0,0);
        add(0,1,0,0,0, 1,0,0,32'd0,0,0,0,0,16'd0,0);
        add(0,0,0,1,0, 0,0,1,W0A,  0,0,1,0,16'd0,0);
        add(0,0,0,1,0, 0,0,1,W1A,  0,0,1,0,16'd0,0);
        add(0,0,0,0,1, 0,0,0,32'd0,1,0,1,0,16'd0,0);
        add(0,0,0,0,0, 0,0,0,32'd0,0,0,0,0,16'd1,0);

`ifdef PRU_ARB_TIMEOUT_EN
        // Watchdog: with no pru_done, the arbiter leaves WAIT_DONE after 8
        // cycles. The error stays set and the next command is still served.
        add(0,1,0,0,0, 1,0,0,32'd0,0,0,0,0,16'd1,0);
        add(0,0,0,1,0, 0,0,1,W0A,  0,0,1,0,16'd1,0);
        add(0,0,0,1,0, 0,0,1,W1A,  0,0,1,0,16'd1,0);
        for (int i = 0; i < 8; i++)
            add(0,0,0,0,0, 0,0,0,32'd0,0,0,1,0,16'd1,0);
        add(0,0,0,0,0, 0,0,0,32'd0,0,0,0,0,16'd1,1);
        add(0,1,0,0,0, 1,0,0,32'd0,0,0,0,0,16'd1,1);
        add(0,0,0,1,0, 0,0,1,W0A,  0,0,1,0,16'd1,1);
        add(0,0,0,1,0, 0,0,1,W1A,  0,0,1,0,16'd1,1);
        add(0,0,0,0,1, 0,0,0,32'd0,1,0,1,0,16'd1,1);
        add(0,0,0,0,0, 0,0,0,32'd0,0,0,0,0,16'd2,1);
`endif

        // Reset state: every output must be zero after several reset edges.
        repeat (3) @(negedge clk);
        #1;
        got = outs();
        total++;
        if (got !== 56'd0) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", got, 56'd0);
        end else begin
            $display("reset_state outputs=%h", got);
        end

        foreach (vecs[i]) begin
            @(negedge clk);
            rst        = vecs[i].rst;
            req0_valid = vecs[i].v0;
            req1_valid = vecs[i].v1;
            pp_ack     = vecs[i].ack;
            pru_done   = vecs[i].pd;
            #1;
            got = outs();
            total++;
            if (got !== vecs[i].exp) begin
                bad++;
                $display("FAIL row%0d got=%h want=%h", i, got, vecs[i].exp);
            end else begin
                $display("row%0d rst=%b v=%b%b ack=%b pru_done=%b outputs=%h",
                         i, vecs[i].rst, vecs[i].v0, vecs[i].v1,
                         vecs[i].ack, vecs[i].pd, got);
            end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
